// File: rtl/fp_normalize_round_pipe.sv
// Normalise / round / pack stage for the FP add/sub datapath, split over three registered
// stages (S1 normalise, S2 round, S3 pack + exception flags) with valid/ready backpressure.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        input handshake
//   in_sign, in_exp, in_mant   raw adder result; in_mant = {carry, hidden, fraction, G, R, S}
//   in_rm                      rounding mode: 00 RNE, 01 RTZ, 10 RUP, 11 RDN
//   out_valid / out_ready      output handshake
//   out_r                      packed {sign, exp, fraction}
//   out_overflow, out_underflow, out_inexact   exception flags, aligned with out_r
module fp_normalize_round_pipe #(
    parameter int unsigned EXP_BITS  = 8,
    parameter int unsigned MANT_BITS = 23
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sign,
    input  logic [EXP_BITS-1:0]           in_exp,
    input  logic [MANT_BITS+4:0]          in_mant,
    input  logic [1:0]                    in_rm,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [EXP_BITS+MANT_BITS:0]   out_r,
    output logic                          out_overflow,
    output logic                          out_underflow,
    output logic                          out_inexact
);

    localparam int unsigned MW = MANT_BITS + 5;  // input mantissa width
    localparam int unsigned NW = MANT_BITS + 4;  // normalised: hidden, fraction, G, R, S
    localparam int unsigned FW = MANT_BITS + 1;  // hidden + fraction
    localparam int unsigned EW = EXP_BITS + 2;   // exponent with headroom for carries
    localparam int unsigned PW = 1 + EXP_BITS + MANT_BITS;

    localparam logic [1:0] RmRne = 2'b00;
    localparam logic [1:0] RmRtz = 2'b01;
    localparam logic [1:0] RmRup = 2'b10;
    localparam logic [1:0] RmRdn = 2'b11;

    localparam logic [EW-1:0] EMax = {2'b00, {EXP_BITS{1'b1}}};

    typedef enum logic [1:0] {KindNum, KindZero, KindInf, KindNan} kind_e;

    // Whole pipe advances together; bubbles travel with the data.
    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // ---------------------------------------------------------------- S1: normalise
    logic          v1_d, v1_q;
    logic          sign1_d, sign1_q;
    logic [1:0]    rm1_d, rm1_q;
    kind_e         kind1_d, kind1_q;
    logic [EW-1:0] e1_d, e1_q;
    logic [NW-1:0] m1_d, m1_q;

    logic [EW-1:0] e_base, lzc, max_shift, shamt;

    always_comb begin
        v1_d    = in_valid;
        sign1_d = in_sign;
        rm1_d   = in_rm;

        // Subnormal inputs share the exponent of the smallest normal.
        e_base = (in_exp == '0) ? EW'(1) : EW'(in_exp);

        // Leading zeros from the hidden bit; the last hit (highest set bit) wins.
        lzc = EW'(NW);
        for (int unsigned i = 0; i < NW; i++) begin
            if (in_mant[i]) lzc = EW'(NW - 1 - i);
        end

        // Never shift below exponent 1: the remainder stays subnormal.
        max_shift = e_base - EW'(1);
        shamt     = (lzc < max_shift) ? lzc : max_shift;

        if (in_mant[MW-1]) begin
            // Carry out of the adder: drop one bit, keep it sticky.
            m1_d = {in_mant[MW-1:2], in_mant[1] | in_mant[0]};
            e1_d = e_base + EW'(1);
        end else begin
            m1_d = in_mant[NW-1:0] << shamt;
            e1_d = e_base - shamt;
        end

        if (in_exp == '1) begin
            kind1_d = (in_mant[MW-3:3] != '0) ? KindNan : KindInf;
        end else if (in_mant == '0) begin
            kind1_d = KindZero;
        end else begin
            kind1_d = KindNum;
        end
    end

    // ---------------------------------------------------------------- S2: round
    logic          v2_d, v2_q;
    logic          sign2_d, sign2_q;
    logic [1:0]    rm2_d, rm2_q;
    kind_e         kind2_d, kind2_q;
    logic [EW-1:0] e2_d, e2_q;
    logic [FW-1:0] mant2_d, mant2_q;
    logic          inexact2_d, inexact2_q;

    logic          lsb, g_bit, rs_bit, inc;
    logic [FW:0]   sum;

    always_comb begin
        v2_d    = v1_q;
        sign2_d = sign1_q;
        rm2_d   = rm1_q;
        kind2_d = kind1_q;

        lsb        = m1_q[3];
        g_bit      = m1_q[2];
        rs_bit     = m1_q[1] | m1_q[0];
        inexact2_d = g_bit | rs_bit;

        unique case (rm1_q)
            RmRne: inc = g_bit & (rs_bit | lsb);
            RmRtz: inc = 1'b0;
            RmRup: inc = ~sign1_q & inexact2_d;
            RmRdn: inc = sign1_q & inexact2_d;
        endcase

        sum = {1'b0, m1_q[NW-1:3]} + {{FW{1'b0}}, inc};

        if (sum[FW]) begin
            // 1.111..1 rounded up to 10.000..0: renormalise.
            mant2_d = {1'b1, {MANT_BITS{1'b0}}};
            e2_d    = e1_q + EW'(1);
        end else begin
            // A subnormal rounding into the hidden bit is picked up at pack time
            // because its exponent is already 1.
            mant2_d = sum[FW-1:0];
            e2_d    = e1_q;
        end
    end

    // ---------------------------------------------------------------- S3: pack
    logic          v3_d, v3_q;
    logic [PW-1:0] r_d, r_q;
    logic          ovf_d, ovf_q;
    logic          unf_d, unf_q;
    logic          inx_d, inx_q;

    logic [EXP_BITS-1:0] exp_field;
    logic                to_inf;

    always_comb begin
        v3_d  = v2_q;
        r_d   = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = 1'b0;

        exp_field = mant2_q[MANT_BITS] ? e2_q[EXP_BITS-1:0] : {EXP_BITS{1'b0}};
        to_inf    = (rm2_q == RmRne) || (rm2_q == RmRup && !sign2_q) ||
                    (rm2_q == RmRdn && sign2_q);

        unique case (kind2_q)
            KindNan:  r_d = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};
            KindInf:  r_d = {sign2_q, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
            KindZero: r_d = {sign2_q, {EXP_BITS{1'b0}}, {MANT_BITS{1'b0}}};
            default: begin
                if (e2_q >= EMax) begin
                    ovf_d = 1'b1;
                    inx_d = 1'b1;
                    if (to_inf) begin
                        r_d = {sign2_q, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
                    end else begin
                        r_d = {sign2_q, {(EXP_BITS-1){1'b1}}, 1'b0, {MANT_BITS{1'b1}}};
                    end
                end else begin
                    r_d   = {sign2_q, exp_field, mant2_q[MANT_BITS-1:0]};
                    inx_d = inexact2_q;
                    unf_d = ~mant2_q[MANT_BITS] & inexact2_q;
                end
            end
        endcase
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            sign1_q    <= 1'b0;
            rm1_q      <= 2'b00;
            kind1_q    <= KindZero;
            e1_q       <= '0;
            m1_q       <= '0;
            v2_q       <= 1'b0;
            sign2_q    <= 1'b0;
            rm2_q      <= 2'b00;
            kind2_q    <= KindZero;
            e2_q       <= '0;
            mant2_q    <= '0;
            inexact2_q <= 1'b0;
            v3_q       <= 1'b0;
            r_q        <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inx_q      <= 1'b0;
        end else if (en) begin
            v1_q       <= v1_d;
            sign1_q    <= sign1_d;
            rm1_q      <= rm1_d;
            kind1_q    <= kind1_d;
            e1_q       <= e1_d;
            m1_q       <= m1_d;
            v2_q       <= v2_d;
            sign2_q    <= sign2_d;
            rm2_q      <= rm2_d;
            kind2_q    <= kind2_d;
            e2_q       <= e2_d;
            mant2_q    <= mant2_d;
            inexact2_q <= inexact2_d;
            v3_q       <= v3_d;
            r_q        <= r_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            inx_q      <= inx_d;
        end
    end

    assign out_valid     = v3_q;
    assign out_r         = r_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
    assign out_inexact   = inx_q;

endmodule

// File: tb/tb_fp_normalize_round_pipe.sv
// Directed bench for fp_normalize_round_pipe (binary32 configuration).
module tb_fp_normalize_round_pipe;

    localparam logic [1:0]  RNE   = 2'b00;
    localparam logic [1:0]  RTZ   = 2'b01;
    localparam logic [1:0]  RUP   = 2'b10;
    localparam logic [1:0]  RDN   = 2'b11;
    localparam logic [27:0] CARRY = 28'h8000000;
    localparam logic [27:0] HID   = 28'h4000000;
    localparam logic [27:0] FLSB  = 28'h0000008;
    localparam logic [27:0] GB    = 28'h0000004;
    localparam logic [27:0] SB    = 28'h0000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_mant;
    logic [1:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_r;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int total = 0;
    int bad   = 0;

    fp_normalize_round_pipe #(
        .EXP_BITS  (8),
        .MANT_BITS (23)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .in_rm         (in_rm),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_r         (out_r),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One isolated word: accepted on the first posedge, result visible 3 edges later.
    task automatic run_one(input string tag, input logic s, input logic [7:0] e,
                           input logic [27:0] m, input logic [1:0] rm,
                           input logic [31:0] er, input logic [2:0] ef);
        @(negedge clk);
        in_valid  = 1'b1;
        in_sign   = s;
        in_exp    = e;
        in_mant   = m;
        in_rm     = rm;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_r"}, out_r, er);
        check({tag, "_flags"}, {29'b0, out_overflow, out_underflow, out_inexact}, {29'b0, ef});
    endtask

    logic [7:0]  bp_exp [4];
    logic [31:0] bp_res [4];
    int          got;
    int          seen;
    logic        acc;

    initial begin
        bp_exp = '{8'h81, 8'h82, 8'h83, 8'h84};
        bp_res = '{32'h40800000, 32'h41000000, 32'h41800000, 32'h42000000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'h00;
        in_mant   = 28'h0;
        in_rm     = RNE;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_r", out_r, 32'h0);
        check("rst_flags", {29'b0, out_overflow, out_underflow, out_inexact}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // flags order: {overflow, underflow, inexact}
        run_one("plain",     1'b0, 8'h81, HID,             RNE, 32'h40800000, 3'b000);
        run_one("carry",     1'b0, 8'h80, CARRY,           RNE, 32'h40800000, 3'b000);
        run_one("rne_g",     1'b0, 8'h7F, HID | FLSB | GB, RNE, 32'h3F800002, 3'b001);
        run_one("rtz_g",     1'b0, 8'h7F, HID | FLSB | GB, RTZ, 32'h3F800001, 3'b001);
        run_one("rne_tie",   1'b0, 8'h7F, HID | GB,        RNE, 32'h3F800000, 3'b001);
        run_one("rup_pos",   1'b0, 8'h7F, HID | GB,        RUP, 32'h3F800001, 3'b001);
        run_one("rdn_pos",   1'b0, 8'h7F, HID | GB,        RDN, 32'h3F800000, 3'b001);
        run_one("carry_stk", 1'b0, 8'h7F, CARRY | SB,      RUP, 32'h40000001, 3'b001);
        run_one("lshift",    1'b0, 8'h85, 28'h1000000,     RNE, 32'h41800000, 3'b000);
        run_one("ovf_rne",   1'b0, 8'hFE, CARRY,           RNE, 32'h7F800000, 3'b101);
        run_one("ovf_rtz",   1'b0, 8'hFE, CARRY,           RTZ, 32'h7F7FFFFF, 3'b101);
        run_one("ovf_rdn",   1'b1, 8'hFE, CARRY,           RDN, 32'hFF800000, 3'b101);
        run_one("subn",      1'b0, 8'h01, 28'h1000000 | SB, RTZ, 32'h00200000, 3'b011);
        run_one("subn_up",   1'b0, 8'h00, 28'h3FFFFF8 | GB, RNE, 32'h00800000, 3'b001);
        run_one("zero_neg",  1'b1, 8'h40, 28'h0,           RNE, 32'h80000000, 3'b000);
        run_one("inf_neg",   1'b1, 8'hFF, HID,             RNE, 32'hFF800000, 3'b000);

        // Backpressure: three words fill the pipe, the fourth must wait.
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            in_valid = 1'b1;
            in_sign  = 1'b0;
            in_exp   = bp_exp[k];
            in_mant  = HID;
            in_rm    = RNE;
            #1;
            check("bp_in_ready", {31'b0, in_ready}, 32'd1);
        end
        @(negedge clk);
        in_exp = bp_exp[3];
        #1;
        check("bp_full_ready", {31'b0, in_ready}, 32'd0);
        check("bp_full_valid", {31'b0, out_valid}, 32'd1);
        check("bp_hold_r", out_r, bp_res[0]);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("bp_stable_r", out_r, bp_res[0]);
            check("bp_stall_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) begin
                if (got < 4) check("bp_order", out_r, bp_res[got]);
                got++;
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) in_valid = 1'b0;
            #1;
        end
        check("bp_count", 32'(got), 32'd4);

        // Reset with two words in flight: neither may come out.
        @(negedge clk);
        in_valid = 1'b1;
        in_exp   = 8'h90;
        in_mant  = HID;
        @(negedge clk);
        in_exp = 8'h91;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_dropped", 32'(seen), 32'd0);

        run_one("qnan", 1'b0, 8'hFF, FLSB, RNE, 32'h7FC00000, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_normalize_round_pipe.md
Name: fp_normalize_round_pipe

Overview:
- Pipelined, parametrised successor to the combinational normalize/round stage of the FP add/sub datapath.
- Accepts the raw adder result (sign, biased exponent, extended mantissa carrying guard/round/sticky bits). Normalises it, rounds it under a selectable IEEE-754 rounding mode, and packs it with exception flags.
- Sits between the mantissa adder and the result register. Uses a valid/ready handshake with full backpressure.

Parameters:
- EXP_BITS, 8, exponent field width
- MANT_BITS, 23, stored fraction width; packed width PW = 1+EXP_BITS+MANT_BITS
- MW, MANT_BITS+5 (derived, not overridable), input mantissa width: [MW-1] carry, [MW-2] hidden, [MW-3:3] fraction, [2] G, [1] R, [0] S

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept input this cycle
- in_sign  in  1  result sign
- in_exp  in  EXP_BITS  biased exponent before normalisation
- in_mant  in  MW  extended mantissa, layout as above
- in_rm  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_r  out  PW  packed {sign, exp, fraction}
- out_overflow  out  1  overflow flag
- out_underflow  out  1  underflow flag (tiny and inexact)
- out_inexact  out  1  result inexact

Behaviour:
- Reset: clk and rst are the only clock/reset; rst is synchronous, active-high. On reset, all stage valid bits, out_valid, out_r and all flags are 0.
- Pipeline structure: 3 registered stages (S1 normalise, S2 round, S3 pack/exceptions). Latency is 3 cycles from input acceptance to out_valid with no stall.
- Enable: global enable en = out_ready | ~out_valid, and in_ready = en.
  - When en=0, every stage register holds, including out_r and flags, which stay stable while out_valid=1 and out_ready=0.
  - Bubbles are not collapsed.
- Transfers: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Special input: in_exp all ones passes through.
  - Fraction nonzero: out_r = canonical qNaN {0, all ones, 1 followed by zeros}.
  - Fraction zero: out_r = signed inf.
  - No flags are set.
- Zero: in_mant == 0 gives signed zero, exp 0, no flags.
- S1 normalise:
  - Effective exponent e = (in_exp==0 ? 1 : in_exp). Compute in EXP_BITS+2 bits signed.
  - If carry=1: shift right 1, e+1, and OR the shifted-out bit into S.
  - Else: let lzc = leading zeros counted from bit MW-2. Shift left by min(lzc, e-1) and subtract the same amount from e.
  - If the hidden bit is still 0 after the shift, the result is subnormal (exp field 0).
- S2 round: increment decision from LSB, G, R|S, sign and rm:
  - RNE: G & (R|S|LSB)
  - RTZ: never
  - RUP: ~sign & (G|R|S)
  - RDN: sign & (G|R|S)
  - inexact = G|R|S.
  - If the increment carries out of the hidden bit: mantissa becomes 1.000…, e+1.
  - A subnormal that rounds into the hidden bit becomes normal with exp 1.
- S3 pack:
  - If e ≥ 2^EXP_BITS−1: overflow=1 and inexact=1. Result is inf for RNE, for RUP with sign 0, and for RDN with sign 1. Otherwise the result is max finite (exp all-ones−1, fraction all ones).
  - underflow = subnormal result & inexact.
- Simultaneous input and output transfer in the same cycle: allowed, throughput 1/cycle.
- Reset mid-operation: all in-flight words are dropped, never emitted; in_ready=1 the cycle after rst deasserts.

Test Plan:
- Plain normalised, RNE: sign 0, in_exp 0x81, in_mant = hidden only -> after 3 cycles out_r=0x40800000, all flags 0.
- Carry right-shift: in_exp 0x80, in_mant = carry bit only -> out_r=0x40800000. Repeat with in_exp 0x7F, in_mant = hidden bit + fraction LSB + G=1, R=S=0, RNE -> out_r=0x3F800002, inexact=1. Same input with RTZ -> 0x3F800001.
- Overflow: in_exp 0xFE, carry set, RNE -> out_r=0x7F800000, overflow=1, inexact=1. RTZ -> 0x7F7FFFFF. RDN with sign 1 -> 0xFF800000.
- Subnormal/underflow: in_exp 0x01, in_mant = fraction bit 21 + S=1, RTZ -> out_r=0x00200000, underflow=1, inexact=1. Zero mantissa with sign 1 -> out_r=0x80000000.
- Backpressure: out_ready=0, push 4 back-to-back words -> in_ready falls after 3 accepted, out_r stable. Raise out_ready -> 3 results in order, then the 4th after re-acceptance, none lost or duplicated.
- Reset mid-stream: assert rst with 2 words in flight -> out_valid=0 next cycle, dropped words never appear. in_exp 0xFF with nonzero fraction -> out_r=0x7FC00000, no flags.
